// File: rtl/riscv_pkg.sv
// Shared integer-pipeline definitions: data width, ALU op codes, operand FIFO states.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
package riscv_pkg;

  localparam int XLEN = 64;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // Occupancy of the 2-entry operand FIFO.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fifo_state_e;

  // A later stage supplies a source only if it writes that register and the
  // register is not x0, which is hardwired to zero and never bypassed.
  function automatic logic fwd_hit(input logic we, input logic [4:0] rd, input logic [4:0] idx);
    return we && (rd == idx) && (idx != 5'd0);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Bypass selection for one source operand: EX/MEM beats MEM/WB beats register file.
// Latency: purely combinational.
// Backpressure: none; sampled by the caller only when it accepts an entry.
// Ports: idx/reg_val = source index and register-file value; exmem_*/memwb_* =
// bypass sources; fwd_val = selected operand value.
module fwd_mux #(
  parameter int XLEN   = 64,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [4:0]      idx,
  input  logic [XLEN-1:0] reg_val,
  input  logic [4:0]      exmem_rd,
  input  logic            exmem_we,
  input  logic [XLEN-1:0] exmem_val,
  input  logic [4:0]      memwb_rd,
  input  logic            memwb_we,
  input  logic [XLEN-1:0] memwb_val,
  output logic [XLEN-1:0] fwd_val
);
  import riscv_pkg::*;

  always_comb begin
    fwd_val = reg_val;
    if (FWD_EN) begin
      // EX/MEM is the younger producer, so it wins when both match.
      if (fwd_hit(exmem_we, exmem_rd, idx)) begin
        fwd_val = exmem_val;
      end else if (fwd_hit(memwb_we, memwb_rd, idx)) begin
        fwd_val = memwb_val;
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Resolves bypassed ALU operands and queues them in a 2-entry FIFO for the ALU.
// Latency: one cycle; an entry accepted at edge N is presented after edge N.
// Backpressure: in_ready is registered (low only when FULL), independent of out_ready.
// Ports: in_* = decode-side handshake and operands; exmem_*/memwb_* = bypass
// sources; flush = discard everything; out_* = registered head-entry payload.
module alu_operand_stage #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rs1_idx,
  input  logic [4:0]      in_rs2_idx,
  input  logic [4:0]      in_rd_idx,
  input  logic            in_srca_pc,
  input  logic            in_srcb_imm,
  input  logic [3:0]      in_aluop,
  input  logic            in_reg_write,
  input  logic [4:0]      exmem_rd,
  input  logic [4:0]      memwb_rd,
  input  logic            exmem_we,
  input  logic            memwb_we,
  input  logic [XLEN-1:0] exmem_val,
  input  logic [XLEN-1:0] memwb_val,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [XLEN-1:0] out_store_data,
  output logic [3:0]      out_aluop,
  output logic [4:0]      out_rd_idx,
  output logic            out_reg_write
);
  import riscv_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] store_data;
    logic [3:0]      aluop;
    logic [4:0]      rd_idx;
    logic            reg_write;
  } entry_t;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  entry_t          new_entry;
  entry_t          head_q;
  entry_t          tail_q;
  fifo_state_e     state_q;
  logic            in_ready_q;
  logic            push;
  logic            pop;

  fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_fwd_rs1 (
    .idx       (in_rs1_idx),
    .reg_val   (in_rs1_val),
    .exmem_rd  (exmem_rd),
    .exmem_we  (exmem_we),
    .exmem_val (exmem_val),
    .memwb_rd  (memwb_rd),
    .memwb_we  (memwb_we),
    .memwb_val (memwb_val),
    .fwd_val   (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_fwd_rs2 (
    .idx       (in_rs2_idx),
    .reg_val   (in_rs2_val),
    .exmem_rd  (exmem_rd),
    .exmem_we  (exmem_we),
    .exmem_val (exmem_val),
    .memwb_rd  (memwb_rd),
    .memwb_we  (memwb_we),
    .memwb_val (memwb_val),
    .fwd_val   (fwd_rs2)
  );

  // Store data always carries the bypassed rs2, even when B takes the immediate.
  always_comb begin
    new_entry.a          = in_srca_pc  ? in_pc  : fwd_rs1;
    new_entry.b          = in_srcb_imm ? in_imm : fwd_rs2;
    new_entry.store_data = fwd_rs2;
    new_entry.aluop      = in_aluop;
    new_entry.rd_idx     = in_rd_idx;
    new_entry.reg_write  = in_reg_write;
  end

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid && out_ready;

  // head_q is always the oldest entry; tail_q is only meaningful in FULL.
  // in_ready_q stays low through reset and rises on the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else if (flush) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          in_ready_q <= 1'b1;
          if (push) begin
            head_q  <= new_entry;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          in_ready_q <= 1'b1;
          if (push && pop) begin
            head_q <= new_entry;
          end else if (push) begin
            tail_q     <= new_entry;
            state_q    <= ST_FULL;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          in_ready_q <= 1'b0;
          if (pop) begin
            head_q     <= tail_q;
            state_q    <= ST_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = (state_q != ST_EMPTY);
  assign out_a          = head_q.a;
  assign out_b          = head_q.b;
  assign out_store_data = head_q.store_data;
  assign out_aluop      = head_q.aluop;
  assign out_rd_idx     = head_q.rd_idx;
  assign out_reg_write  = head_q.reg_write;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [63:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
  logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd_idx;
  logic        in_srca_pc, in_srcb_imm;
  logic [3:0]  in_aluop;
  logic        in_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_we, memwb_we;
  logic [63:0] exmem_val, memwb_val;
  logic        flush;
  logic        out_valid, out_ready;
  logic [63:0] out_a, out_b, out_store_data;
  logic [3:0]  out_aluop;
  logic [4:0]  out_rd_idx;
  logic        out_reg_write;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd_idx(in_rd_idx),
    .in_srca_pc(in_srca_pc), .in_srcb_imm(in_srcb_imm),
    .in_aluop(in_aluop), .in_reg_write(in_reg_write),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .exmem_val(exmem_val), .memwb_val(memwb_val),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_store_data(out_store_data),
    .out_aluop(out_aluop), .out_rd_idx(out_rd_idx), .out_reg_write(out_reg_write)
  );

  typedef struct {
    string       name;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic [63:0] rs1_val, rs2_val, pc, imm;
    logic        srca_pc, srcb_imm;
    logic [4:0]  ex_rd;  logic ex_we;  logic [63:0] ex_val;
    logic [4:0]  wb_rd;  logic wb_we;  logic [63:0] wb_val;
    logic [3:0]  aluop;
    logic        reg_write;
    logic [63:0] exp_a, exp_b, exp_sd;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_pc = 0; in_rs1_val = 0; in_rs2_val = 0; in_imm = 0;
    in_rs1_idx = 0; in_rs2_idx = 0; in_rd_idx = 0; in_srca_pc = 0; in_srcb_imm = 0;
    in_aluop = 0; in_reg_write = 0;
    exmem_rd = 0; memwb_rd = 0; exmem_we = 0; memwb_we = 0; exmem_val = 0; memwb_val = 0;
  endtask

  // Simple entry tagged by x: out_a = x, no bypass involvement.
  task automatic drive_tag(input logic [63:0] x);
    in_rs1_idx = 5'd1; in_rs1_val = x; in_rs2_idx = 5'd2; in_rs2_val = ~x;
    in_srca_pc = 0; in_srcb_imm = 0; exmem_we = 0; memwb_we = 0;
    in_aluop = x[3:0]; in_rd_idx = x[4:0]; in_reg_write = 1;
  endtask

  initial begin
    //        name       rs1 rs2 rd  rs1_val  rs2_val  pc        imm                    sa sb  ex_rd we ex_val  wb_rd we wb_val aluop rw  exp_a      exp_b                  exp_sd
    vecs[0] = '{"exmem_prio", 5, 3, 10, 64'h1,  64'h33,  64'h0,    64'h0,                 0, 0, 5, 1, 64'hAA, 5, 1, 64'hBB, 4'd0, 1, 64'hAA,   64'h33,                64'h33};
    vecs[1] = '{"x0_nofwd",   0, 0, 11, 64'h9,  64'h7,   64'h0,    64'h0,                 0, 0, 0, 1, 64'h55, 0, 1, 64'h66, 4'd1, 1, 64'h9,    64'h7,                 64'h7};
    vecs[2] = '{"imm_b",      2, 8, 12, 64'h20, 64'h99,  64'h0,    64'hFFFF_FFFF_FFFF_FFFC,0, 1, 8, 1, 64'h10, 0, 0, 64'h0,  4'd5, 0, 64'h20,   64'hFFFF_FFFF_FFFF_FFFC, 64'h10};
    vecs[3] = '{"memwb_only", 7, 6, 13, 64'h1,  64'h66,  64'h0,    64'h0,                 0, 0, 7, 0, 64'hEE, 7, 1, 64'h77, 4'd7, 1, 64'h77,   64'h66,                64'h66};
    vecs[4] = '{"pc_a",       9, 4, 14, 64'h1,  64'h2,   64'h1000, 64'h0,                 1, 0, 9, 1, 64'h99, 4, 1, 64'h44, 4'd9, 1, 64'h1000, 64'h44,                64'h44};
    vecs[5] = '{"no_we",      3, 3, 15, 64'h3,  64'h5,   64'h0,    64'h0,                 0, 0, 3, 0, 64'hAA, 3, 0, 64'hBB, 4'd8, 0, 64'h3,    64'h5,                 64'h5};

    idle_inputs();
    flush = 0; out_ready = 0; rst_n = 0;

    // Reset state
    #12;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd0);
    check("rst_out_a", out_a, 64'd0);
    check("rst_out_b", out_b, 64'd0);
    check("rst_out_sd", out_store_data, 64'd0);
    check("rst_side", {54'b0, out_aluop, out_rd_idx, out_reg_write}, 64'd0);
    @(negedge clk); rst_n = 1;
    check("rst_rel_in_ready_lo", {63'b0, in_ready}, 64'd0);
    @(negedge clk);
    check("rst_rel_in_ready_hi", {63'b0, in_ready}, 64'd1);

    // Table-driven forwarding vectors
    for (int i = 0; i < 6; i++) begin
      in_rs1_idx = vecs[i].rs1_idx; in_rs2_idx = vecs[i].rs2_idx; in_rd_idx = vecs[i].rd_idx;
      in_rs1_val = vecs[i].rs1_val; in_rs2_val = vecs[i].rs2_val;
      in_pc = vecs[i].pc; in_imm = vecs[i].imm;
      in_srca_pc = vecs[i].srca_pc; in_srcb_imm = vecs[i].srcb_imm;
      exmem_rd = vecs[i].ex_rd; exmem_we = vecs[i].ex_we; exmem_val = vecs[i].ex_val;
      memwb_rd = vecs[i].wb_rd; memwb_we = vecs[i].wb_we; memwb_val = vecs[i].wb_val;
      in_aluop = vecs[i].aluop; in_reg_write = vecs[i].reg_write;
      in_valid = 1; out_ready = 0;
      @(negedge clk);
      // Held entry must not pick up later bypass values.
      in_valid = 0; exmem_val = 64'hDEAD_BEEF_0000_0001; memwb_val = 64'hDEAD_BEEF_0000_0002;
      in_rs1_val = 64'hBAD1; in_rs2_val = 64'hBAD2;
      @(negedge clk);
      check({vecs[i].name, "_valid"}, {63'b0, out_valid}, 64'd1);
      check({vecs[i].name, "_a"}, out_a, vecs[i].exp_a);
      check({vecs[i].name, "_b"}, out_b, vecs[i].exp_b);
      check({vecs[i].name, "_sd"}, out_store_data, vecs[i].exp_sd);
      check({vecs[i].name, "_side"}, {54'b0, out_aluop, out_rd_idx, out_reg_write},
            {54'b0, vecs[i].aluop, vecs[i].rd_idx, vecs[i].reg_write});
      out_ready = 1;
      @(negedge clk);
      check({vecs[i].name, "_popped"}, {63'b0, out_valid}, 64'd0);
      out_ready = 0;
    end
    idle_inputs();

    // Fill with backpressure: third entry must be refused, order preserved.
    drive_tag(64'hA1); in_valid = 1;
    @(negedge clk);
    check("fill1_in_ready", {63'b0, in_ready}, 64'd1);
    drive_tag(64'hB2);
    @(negedge clk);
    check("fill2_in_ready", {63'b0, in_ready}, 64'd0);
    drive_tag(64'hC3);
    @(negedge clk);
    check("fill3_head_stable", out_a, 64'hA1);
    check("fill3_in_ready", {63'b0, in_ready}, 64'd0);
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    check("drain1_in_ready", {63'b0, in_ready}, 64'd1);
    check("drain1_a", out_a, 64'hB2);
    check("drain1_valid", {63'b0, out_valid}, 64'd1);
    @(negedge clk);
    check("drain2_valid", {63'b0, out_valid}, 64'd0);
    out_ready = 0;

    // Simultaneous push and pop in ONE
    drive_tag(64'h11); in_valid = 1;
    @(negedge clk);
    drive_tag(64'h22); out_ready = 1;
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    check("pushpop_valid", {63'b0, out_valid}, 64'd1);
    check("pushpop_a", out_a, 64'h22);
    check("pushpop_in_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1;
    @(negedge clk);
    check("pushpop_drained", {63'b0, out_valid}, 64'd0);
    out_ready = 0;

    // Flush while FULL with a simultaneous arrival
    drive_tag(64'h31); in_valid = 1;
    @(negedge clk);
    drive_tag(64'h32);
    @(negedge clk);
    check("flush_pre_full", {63'b0, in_ready}, 64'd0);
    drive_tag(64'h33); flush = 1;
    @(negedge clk);
    flush = 0; in_valid = 0;
    check("flush_valid", {63'b0, out_valid}, 64'd0);
    check("flush_in_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check("flush_nothing_emerges", {63'b0, out_valid}, 64'd0);
    out_ready = 0;

    // Asynchronous reset while FULL
    drive_tag(64'h41); in_valid = 1;
    @(negedge clk);
    drive_tag(64'h42);
    @(negedge clk);
    in_valid = 0;
    check("rstfull_pre_valid", {63'b0, out_valid}, 64'd1);
    #2 rst_n = 0;
    #1;
    check("rstfull_valid", {63'b0, out_valid}, 64'd0);
    check("rstfull_in_ready", {63'b0, in_ready}, 64'd0);
    @(negedge clk); rst_n = 1;
    check("rstfull_rel_lo", {63'b0, in_ready}, 64'd0);
    @(negedge clk);
    check("rstfull_rel_hi", {63'b0, in_ready}, 64'd1);
    check("rstfull_empty", {63'b0, out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter XLEN, default 64, operand and data width.
REQ-002 Parameter FWD_EN, default 1, enables EX/MEM and MEM/WB forwarding; 0 passes register values unchanged.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid / in_ready  input / output  1 / 1  upstream (decode) handshake; transfer when both high at a rising edge.
REQ-006 in_pc, in_rs1_val, in_rs2_val, in_imm  input  XLEN each  decoded operands.
REQ-007 in_rs1_idx, in_rs2_idx, in_rd_idx  input  5 each  register indices.
REQ-008 in_srca_pc, in_srcb_imm  input  1 each  select A=pc instead of rs1, B=imm instead of rs2.
REQ-009 in_aluop  input  4  ALU operation code; in_reg_write  input  1  destination write enable.
REQ-010 exmem_rd, memwb_rd  input  5 each; exmem_we, memwb_we  input  1 each; exmem_val, memwb_val  input  XLEN each  forwarding sources.
REQ-011 flush  input  1  synchronous discard of all held and arriving entries.
REQ-012 out_valid / out_ready  output / input  1 / 1  downstream (ALU) handshake.
REQ-013 out_a, out_b, out_store_data  output  XLEN each  ALU A, ALU B, forwarded rs2.
REQ-014 out_aluop 4, out_rd_idx 5, out_reg_write 1  outputs  registered sideband.

Function
REQ-015 Forwarding per source operand at acceptance: exmem_val if exmem_we and exmem_rd==idx and idx!=0; else memwb_val if memwb_we and memwb_rd==idx and idx!=0; else register value.
REQ-016 Index 0 never forwarded; rs1_idx=0 or rs2_idx=0 with register value nonzero still passes register value.
REQ-017 out_a = in_srca_pc ? in_pc : fwd_rs1; out_b = in_srcb_imm ? in_imm : fwd_rs2; out_store_data = fwd_rs2 regardless of in_srcb_imm.
REQ-018 Storage is a 2-entry FIFO; states EMPTY, ONE, FULL; head entry drives all out_* signals.
REQ-019 Latency: entry accepted at edge N appears with out_valid=1 after edge N; no combinational path in_* -> out_*.
REQ-020 in_ready is a register: 1 in EMPTY and ONE, 0 in FULL; no combinational dependence on out_ready.
REQ-021 Transitions: push only -> EMPTY->ONE, ONE->FULL; pop only -> FULL->ONE, ONE->EMPTY; push and pop in ONE -> stays ONE, order preserved.
REQ-022 In FULL with out_ready=1: pop to ONE; no push that cycle since in_ready=0.
REQ-023 Payload of head entry is stable while out_valid=1 and out_ready=0.
REQ-024 flush=1 at an edge: next state EMPTY, out_valid=0, in_ready=1; a simultaneous in_valid entry is dropped; flush takes priority over push and pop.
REQ-025 Held entries are not re-forwarded; hazard control upstream guarantees no younger writeback to a held entry's source.

Reset
REQ-026 rst_n low: state EMPTY, out_valid=0, in_ready=0, out_a/out_b/out_store_data=0, out_aluop=0, out_rd_idx=0, out_reg_write=0.
REQ-027 in_ready rises to 1 at the first rising edge after rst_n deasserts; reset mid-transfer discards all entries.

Structure
REQ-028 XLEN, ALU operation code constants and FIFO state encoding reside in shared package riscv_pkg.
REQ-029 Forwarding selection is one sub-module fwd_mux, instantiated once per source operand (rs1, rs2).

Verification
REQ-030 rs1_idx=5, rs1_val=1, exmem_rd=5/we=1/val=0xAA, memwb_rd=5/we=1/val=0xBB -> out_a=0xAA one cycle later.
REQ-031 rs2_idx=0, rs2_val=7, exmem_rd=0/we=1/val=0x55 -> out_b=7, out_store_data=7.
REQ-032 srcb_imm=1, imm=-4, rs2 forwarded 0x10 -> out_b=0xFFFF_FFFF_FFFF_FFFC, out_store_data=0x10.
REQ-033 out_ready=0, push 3 entries back-to-back -> 2 accepted, in_ready=0 after second; release -> outputs in order, in_ready=1 after first pop.
REQ-034 FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry emerges.
REQ-035 rst_n low while FULL -> out_valid=0 immediately, in_ready=0; in_ready=1 one edge after release.
